// File: rtl/sram_portb_pkg.sv
// Shared defaults, FSM encoding and read-tag layout for the port-B SRAM arbiter.
package sram_portb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 128;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // idx is wide enough for the largest supported requester count (8)
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker with an optional lock onto a single requester.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               lock_en,
  input  logic [PTR_W-1:0]   lock_idx,
  output logic [NUM_REQ-1:0] grant
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   first_rot;
  logic [2*NUM_REQ-1:0] first_dbl;
  logic [NUM_REQ-1:0]   grant_rr;
  logic [NUM_REQ-1:0]   lock_sel;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  assign req_dbl   = {req, req};
  assign req_rot   = req_dbl[ptr +: NUM_REQ];
  assign first_rot = req_rot & (~req_rot + NUM_REQ'(1));
  assign first_dbl = {first_rot, first_rot} << ptr;
  assign grant_rr  = first_dbl[2*NUM_REQ-1 -: NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lock_sel
      assign lock_sel[gi] = (lock_idx == PTR_W'(gi));
    end
  endgenerate

  assign grant = lock_en ? (req & lock_sel) : grant_rr;

endmodule

// File: rtl/sram_portb_arbiter.sv
// Round-robin arbiter with burst lock for SRAM port B; routes read data back by tag.
// Optional counters: define SRAM_PORTB_ARB_PERF_EN.
module sram_portb_arbiter
  import sram_portb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                        pll_core_cpuclk,
  input  logic                        pad_cpu_rst_b,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           dram1_portb_addr,
  output logic [DATA_W-1:0]           dram1_portb_din,
  output logic [DATA_W/8-1:0]         dram1_portb_wen,
  input  logic [DATA_W-1:0]           dram1_portb_dout
`ifdef SRAM_PORTB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]       perf_grant_cnt,
  output logic [31:0]                 perf_conflict_cnt
`endif
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_W / 8;

  arb_state_t         state_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   owner_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  din_reg;
  logic [STRB_W-1:0]  wen_reg;
  rd_tag_t            tag_reg [RD_LAT+1];

  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic [PTR_W-1:0]   acc_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;
  logic               sel_we;
  logic               sel_last;
  rd_tag_t            tag_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (rr_ptr_reg),
    .lock_en  (state_reg == LOCKED),
    .lock_idx (owner_reg),
    .grant    (grant)
  );

  // No handshakes are offered while reset is held.
  assign req_ready = pad_cpu_rst_b ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    acc_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_we    = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        acc_idx   = PTR_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
        sel_we    = req_we[i];
        sel_last  = req_last[i];
      end
    end
  end

  assign ptr_next = (acc_idx == PTR_W'(NUM_REQ - 1)) ? '0 : acc_idx + PTR_W'(1);
  assign tag_in   = '{valid: accept && !sel_we, idx: 3'(acc_idx)};

  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      addr_reg   <= '0;
      din_reg    <= '0;
      wen_reg    <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_reg[k] <= '0;
    end else begin
      wen_reg <= '0;
      if (accept) begin
        addr_reg <= sel_addr;
        if (sel_we) begin
          wen_reg <= sel_wstrb;
          din_reg <= sel_wdata;
        end
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (!sel_last) begin
              state_reg <= LOCKED;
              owner_reg <= acc_idx;
            end else begin
              rr_ptr_reg <= ptr_next;
            end
          end
        end
        LOCKED: begin
          if (accept && sel_last) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= ptr_next;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Stage 0 covers the issue register; the rest mirror the SRAM latency.
      tag_reg[0] <= tag_in;
      for (int k = 1; k <= RD_LAT; k++) tag_reg[k] <= tag_reg[k-1];
    end
  end

  assign dram1_portb_addr = addr_reg;
  assign dram1_portb_din  = din_reg;
  assign dram1_portb_wen  = wen_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = tag_reg[RD_LAT].valid && (tag_reg[RD_LAT].idx == 3'(gi));
    end
  endgenerate

  assign rsp_rdata = (|rsp_valid) ? dram1_portb_dout : '0;

`ifdef SRAM_PORTB_ARB_PERF_EN
  logic [31:0]        conflict_cnt_reg;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               multi_valid;
  logic               lock_block;

  assign owner_onehot = NUM_REQ'(1) << owner_reg;
  assign multi_valid  = |(req_valid & (req_valid - NUM_REQ'(1)));
  assign lock_block   = (state_reg == LOCKED) && (|(req_valid & ~owner_onehot));

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf_grant
      logic [31:0] grant_cnt_reg;
      always_ff @(posedge pll_core_cpuclk) begin
        if (!pad_cpu_rst_b) begin
          grant_cnt_reg <= '0;
        end else if (req_ready[gi]) begin
          grant_cnt_reg <= grant_cnt_reg + 32'd1;
        end
      end
      assign perf_grant_cnt[gi*32 +: 32] = grant_cnt_reg;
    end
  endgenerate

  always_ff @(posedge pll_core_cpuclk) begin
    if (!pad_cpu_rst_b) begin
      conflict_cnt_reg <= '0;
    end else if (multi_valid || lock_block) begin
      conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  assign perf_conflict_cnt = conflict_cnt_reg;
`endif

endmodule
